tff_mod_counter: RTL

Synchronous modulo-N up/down counter built from per-bit toggle logic. Each cycle it computes the T input for every bit and toggles the state register with it, giving the same q/qb behaviour as our single-bit T flip-flop. It sits directly upstream of the single-bit T flip-flop stages: `t_vec` drives their T inputs, and `wrap` carries into the next counter stage.

---
 rtl/tff_mod_counter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tff_mod_counter.sv
// tff_mod_counter
//
// Synchronous modulo-MODULUS up/down counter built from per-bit toggle logic.
// Each cycle the next count is computed, and the per-bit toggle vector
// t_vec = q ^ next_q is derived from it. The state register only ever updates
// as q <= q ^ t_vec, which mirrors the behaviour of a bank of single-bit
// T flip-flops. t_vec is exported so downstream T flip-flop stages can be
// driven directly, and wrap carries into the next counter stage.
//
// Parameters:
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1, legal range 2..2**WIDTH
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   en        in   count enable
//   up        in   direction, 1 = up, 0 = down
//   load      in   synchronous parallel load of d (beats en)
//   d         in   load value
//   q         out  registered count
//   qb        out  bitwise complement of q
//   t_vec     out  combinational per-bit toggle vector (q ^ next_q)
//   tc        out  combinational terminal count
//   wrap      out  registered one-cycle wrap pulse
//   load_err  out  registered one-cycle out-of-range load flag

module tff_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // An out-of-range modulus would let the count escape its range, so refuse
  // to elaborate rather than build a broken counter.
  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("tff_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  // MOD_EXT is one bit wider so MODULUS == 2**WIDTH still compares correctly
  // against an extended load value.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  logic [WIDTH-1:0] next_q;
  logic             wrap_next;
  logic             load_err_next;
  logic             at_top;
  logic             at_bottom;
  logic             load_in_range;

  assign at_top        = (q == MAX_VAL);
  assign at_bottom     = (q == ZERO);
  assign load_in_range = ({1'b0, d} < MOD_EXT);

  // Next-count selection with load above count enable. Every hold case
  // leaves next_q equal to q, which makes t_vec zero. Reset is not folded in
  // here: t_vec describes the counting path the T stages follow.
  always_comb begin
    next_q        = q;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    if (load) begin
      if (load_in_range) begin
        next_q = d;
      end else begin
        next_q        = ZERO;
        load_err_next = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          next_q    = ZERO;
          wrap_next = 1'b1;
        end else begin
          next_q = q + ONE;
        end
      end else begin
        if (at_bottom) begin
          next_q    = MAX_VAL;
          wrap_next = 1'b1;
        end else begin
          next_q = q - ONE;
        end
      end
    end
  end

  assign t_vec = q ^ next_q;
  assign qb    = ~q;
  assign tc    = en & ~load & (up ? at_top : at_bottom);

  // State register: toggles exactly the bits flagged in t_vec. The two
  // status flags are re-evaluated every edge so each pulse lasts one cycle
  // unless its cause repeats on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= ZERO;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= q ^ t_vec;
      wrap     <= wrap_next;
      load_err <= load_err_next;
    end
  end

endmodule
